// File: rtl/pixel_writer.sv
// pixel_writer: clips an (x, y) pixel stream to the active frame and turns each
// surviving pixel into a linear framebuffer address. Writes are buffered in a
// FIFO and issued over a req/ack memory port. The source cannot be stalled, so
// pixels lost to a full FIFO are reported on a sticky flag.
module pixel_writer #(
  parameter int P_X_COORD_W = 11,
  parameter int P_Y_COORD_W = 11,
  parameter int P_H_RES     = 640,
  parameter int P_V_RES     = 480,
  parameter int P_ADDR_W    = 19,
  parameter int P_COLOR_W   = 8,
  parameter int P_FIFO_AW   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [P_X_COORD_W-1:0] i_x_val,
  input  logic [P_Y_COORD_W-1:0] i_y_val,
  input  logic                   i_vals_rdy,
  input  logic [P_COLOR_W-1:0]   i_color,
  input  logic                   i_clear,
  output logic [P_ADDR_W-1:0]    o_mem_addr,
  output logic [P_COLOR_W-1:0]   o_mem_data,
  output logic                   o_mem_req,
  input  logic                   i_mem_ack,
  output logic                   o_busy,
  output logic                   o_overflow,
  output logic [15:0]            o_clip_cnt
);

  localparam int DEPTH   = 1 << P_FIFO_AW;
  // Wide enough for (max y) * P_H_RES + (max x) without wrap before truncation.
  localparam int MUL_W   = P_Y_COORD_W + $clog2(P_H_RES) + 2;
  localparam int ENTRY_W = P_ADDR_W + P_COLOR_W;

  localparam logic [P_X_COORD_W:0] XLIM = (P_X_COORD_W+1)'(P_H_RES);
  localparam logic [P_Y_COORD_W:0] YLIM = (P_Y_COORD_W+1)'(P_V_RES);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [P_ADDR_W-1:0] trunc_addr(input logic [MUL_W-1:0] v);
    return v[P_ADDR_W-1:0];
  endfunction

  // ---- stage 1: capture and clip ----
  logic                   w_in_range;
  logic                   w_clip;
  logic                   r_vld_p1;
  logic [P_X_COORD_W-1:0] r_x_p1;
  logic [P_Y_COORD_W-1:0] r_y_p1;
  logic [P_COLOR_W-1:0]   r_color_p1;

  assign w_in_range = ({1'b0, i_x_val} < XLIM) && ({1'b0, i_y_val} < YLIM);
  assign w_clip     = i_vals_rdy && !w_in_range;

  // Stage 1 valid: only in-frame pixels continue down the pipe.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_vld_p1 <= 1'b0;
    else         r_vld_p1 <= i_vals_rdy && w_in_range;
  end

  // Stage 1 data capture on every strobe.
  always_ff @(posedge i_clk) begin
    if (i_vals_rdy) begin
      r_x_p1     <= i_x_val;
      r_y_p1     <= i_y_val;
      r_color_p1 <= i_color;
    end
  end

  // ---- stage 2: linear address ----
  logic [MUL_W-1:0]     w_addr_full;
  logic                 r_vld_p2;
  logic [P_ADDR_W-1:0]  r_addr_p2;
  logic [P_COLOR_W-1:0] r_color_p2;

  assign w_addr_full = MUL_W'(r_y_p1) * MUL_W'(P_H_RES) + MUL_W'(r_x_p1);

  // Stage 2 valid follows stage 1 by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_vld_p2 <= 1'b0;
    else         r_vld_p2 <= r_vld_p1;
  end

  // Stage 2 data: registered address and colour.
  always_ff @(posedge i_clk) begin
    if (r_vld_p1) begin
      r_addr_p2  <= trunc_addr(w_addr_full);
      r_color_p2 <= r_color_p1;
    end
  end

  // ---- FIFO and output register ----
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [P_FIFO_AW-1:0] r_wr_ptr;
  logic [P_FIFO_AW-1:0] r_rd_ptr;
  logic [P_FIFO_AW:0]   r_count;
  logic                 w_fifo_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  assign w_fifo_full = (r_count == (P_FIFO_AW+1)'(DEPTH));
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign w_pop       = (r_count != '0) && (!o_mem_req || i_mem_ack);
  assign w_push      = r_vld_p2 && (!w_fifo_full || w_pop);
  assign w_drop      = r_vld_p2 && !w_push;

  // FIFO storage write.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_addr_p2, r_color_p2};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Output register: load the FIFO head when free, hold while unacknowledged.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
    end else if (w_pop) begin
      o_mem_req                <= 1'b1;
      {o_mem_addr, o_mem_data} <= r_mem[r_rd_ptr];
    end else if (i_mem_ack) begin
      o_mem_req <= 1'b0;
    end
  end

  // Status: sticky overflow and saturating clip counter; clear beats events.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      o_overflow <= 1'b0;
      o_clip_cnt <= '0;
    end else begin
      if (w_drop) o_overflow <= 1'b1;
      if (w_clip) o_clip_cnt <= sat_inc16(o_clip_cnt);
    end
  end

  assign o_busy = r_vld_p1 || r_vld_p2 || (r_count != '0) || o_mem_req;

endmodule

// File: tb/tb_pixel_writer.sv
// Testbench for pixel_writer: directed scenarios plus a randomized phase, with
// a queue-based scoreboard fed at stimulus time and drained by a write monitor.
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] x_val, y_val;
  logic        vals_rdy;
  logic [7:0]  color;
  logic        clr;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_req;
  logic        mem_ack;
  logic        busy;
  logic        ovf;
  logic [15:0] clip_cnt;

  pixel_writer dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_x_val    (x_val),
    .i_y_val    (y_val),
    .i_vals_rdy (vals_rdy),
    .i_color    (color),
    .i_clear    (clr),
    .o_mem_addr (mem_addr),
    .o_mem_data (mem_data),
    .o_mem_req  (mem_req),
    .i_mem_ack  (mem_ack),
    .o_busy     (busy),
    .o_overflow (ovf),
    .o_clip_cnt (clip_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [26:0] exp_q[$];
  int clip_exp = 0;
  int hi_cnt = 0;
  int rise_cnt = 0;
  logic prev_req = 1'b0;
  logic hold_v = 1'b0;
  logic [18:0] held_addr;
  logic [7:0]  held_data;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one strobe; the reference model decides clip vs. expected write.
  task automatic issue(input int px, input int py, input int pc, input bit keep);
    x_val    = 11'(px);
    y_val    = 11'(py);
    color    = 8'(pc);
    vals_rdy = 1'b1;
    if (px < 640 && py < 480) begin
      if (keep) exp_q.push_back({19'(py * 640 + px), 8'(pc)});
    end else begin
      clip_exp++;
    end
    step();
    vals_rdy = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 300) begin
      step();
      k++;
    end
    check(name, int'(busy), 0);
  endtask

  // Write monitor: pops the scoreboard on every completed write and checks
  // that a stalled request holds its address and data.
  always @(negedge clk) begin
    if (mem_req) hi_cnt++;
    if (mem_req && !prev_req) rise_cnt++;
    prev_req = mem_req;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (mem_req && hold_v) begin
        check("hold_addr", int'(mem_addr), int'(held_addr));
        check("hold_data", int'(mem_data), int'(held_data));
      end
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0d, expected none", mem_addr);
        end else begin
          logic [26:0] e;
          e = exp_q.pop_front();
          check("wr_addr", int'(mem_addr), int'(e[26:8]));
          check("wr_data", int'(mem_data), int'(e[7:0]));
        end
        hold_v = 1'b0;
      end else if (mem_req) begin
        hold_v    = 1'b1;
        held_addr = mem_addr;
        held_data = mem_data;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic req_at [1:5];
    rst = 1'b1; x_val = '0; y_val = '0; vals_rdy = 1'b0; color = '0;
    clr = 1'b0; mem_ack = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // reset state
    check("rst_req", int'(mem_req), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_data", int'(mem_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_clip", int'(clip_cnt), 0);

    // single pixel: latency and one-cycle request
    mem_ack = 1'b1;
    hi_cnt = 0; rise_cnt = 0;
    issue(3, 2, 8'h5A, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      req_at[i] = mem_req;
    end
    step();
    check("lat_req_n3", int'(req_at[3]), 0);
    check("lat_req_n4", int'(req_at[4]), 1);
    check("lat_req_n5", int'(req_at[5]), 0);
    wait_idle("single_idle");
    check("single_hi_cycles", hi_cnt, 1);
    check("single_sb_empty", exp_q.size(), 0);

    // clipping boundaries
    issue(640, 0, 8'h11, 1'b1);
    issue(0, 480, 8'h22, 1'b1);
    issue(639, 479, 8'h33, 1'b1);
    wait_idle("clip_idle");
    check("clip_cnt", int'(clip_cnt), clip_exp);
    check("clip_cnt_is2", int'(clip_cnt), 2);
    check("clip_sb_empty", exp_q.size(), 0);

    // back-to-back burst
    hi_cnt = 0; rise_cnt = 0;
    for (int i = 0; i < 8; i++) issue(10 + i, 5, 8'(8'h80 + i), 1'b1);
    wait_idle("burst_idle");
    check("burst_hi_cycles", hi_cnt, 8);
    check("burst_rises", rise_cnt, 1);
    check("burst_sb_empty", exp_q.size(), 0);

    // stall overflow: 17 retained of 20
    mem_ack = 1'b0;
    for (int i = 0; i < 20; i++) issue(i, 100, int'($urandom_range(0, 255)), i < 17);
    repeat (4) step();
    check("ovf_set", int'(ovf), 1);
    check("ovf_req_held", int'(mem_req), 1);
    mem_ack = 1'b1;
    wait_idle("ovf_idle");
    check("ovf_sb_empty", exp_q.size(), 0);

    // toggling ack, then clear
    for (int i = 0; i < 6; i++) begin
      mem_ack = i[0] ? 1'b0 : 1'b1;
      issue(200 + i, 300, int'($urandom_range(0, 255)), 1'b1);
    end
    for (int i = 0; i < 20; i++) begin
      mem_ack = ~mem_ack;
      step();
    end
    mem_ack = 1'b1;
    wait_idle("tog_idle");
    check("tog_sb_empty", exp_q.size(), 0);
    check("pre_clear_ovf", int'(ovf), 1);
    clr = 1'b1;
    clip_exp = 0;
    step();
    clr = 1'b0;
    check("clear_ovf", int'(ovf), 0);
    check("clear_clip", int'(clip_cnt), 0);

    // reset with a pending request and 5 queued entries
    mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) issue(i, 7, i, 1'b1);
    repeat (4) step();
    check("prerst_req", int'(mem_req), 1);
    rst = 1'b1;
    exp_q.delete();
    clip_exp = 0;
    step();
    rst = 1'b0;
    check("midrst_req", int'(mem_req), 0);
    check("midrst_busy", int'(busy), 0);
    hi_cnt = 0;
    mem_ack = 1'b1;
    repeat (20) step();
    check("midrst_no_req", hi_cnt, 0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      mem_ack = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 3)
        issue(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
              int'($urandom_range(0, 255)), 1'b1);
      else
        step();
    end
    mem_ack = 1'b1;
    wait_idle("rand_idle");
    check("rand_sb_empty", exp_q.size(), 0);
    check("rand_clip", int'(clip_cnt), clip_exp);
    check("rand_ovf", int'(ovf), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
